// File: rtl/reservation_station.sv
// reservation_station: buffers dispatched ops until both operands are known, issues the oldest ready one.
// Optional macro RS_WAKEUP_BYPASS_EN: a CDB wakeup makes the entry issuable in the same cycle.
module reservation_station #(
    parameter int RS_DEPTH   = 8,
    parameter int CDB_DEPTH  = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TAG_WIDTH  = 6
) (
    input  logic                                 clk,
    input  logic                                 n_rst,
    input  logic                                 i_flush,
    input  logic [CDB_DEPTH-1:0]                 i_cdb_en,
    input  logic [CDB_DEPTH-1:0][TAG_WIDTH-1:0]  i_cdb_tag,
    input  logic [CDB_DEPTH-1:0][DATA_WIDTH-1:0] i_cdb_data,
    input  logic                                 i_rs_en,
    input  logic [6:0]                           i_rs_opcode,
    input  logic [ADDR_WIDTH-1:0]                i_rs_iaddr,
    input  logic [DATA_WIDTH-1:0]                i_rs_insn,
    input  logic [1:0][TAG_WIDTH-1:0]            i_rs_src_tag,
    input  logic [1:0][DATA_WIDTH-1:0]           i_rs_src_data,
    input  logic [1:0]                           i_rs_src_rdy,
    input  logic [TAG_WIDTH-1:0]                 i_rs_dst_tag,
    output logic                                 o_rs_stall,
    input  logic                                 i_fu_stall,
    output logic                                 o_fu_valid,
    output logic [6:0]                           o_fu_opcode,
    output logic [ADDR_WIDTH-1:0]                o_fu_iaddr,
    output logic [DATA_WIDTH-1:0]                o_fu_insn,
    output logic [DATA_WIDTH-1:0]                o_fu_src_a,
    output logic [DATA_WIDTH-1:0]                o_fu_src_b,
    output logic [TAG_WIDTH-1:0]                 o_fu_tag
);
    localparam int IDX_W = $clog2(RS_DEPTH);

    logic [RS_DEPTH-1:0]              valid_q;
    logic [RS_DEPTH-1:0]              age_q [RS_DEPTH];
    logic [6:0]                       opcode_q [RS_DEPTH];
    logic [ADDR_WIDTH-1:0]            iaddr_q [RS_DEPTH];
    logic [DATA_WIDTH-1:0]            insn_q [RS_DEPTH];
    logic [TAG_WIDTH-1:0]             dst_q [RS_DEPTH];
    logic [1:0][TAG_WIDTH-1:0]        src_tag_q [RS_DEPTH];
    logic [1:0][DATA_WIDTH-1:0]       src_data_q [RS_DEPTH];
    logic [1:0]                       src_rdy_q [RS_DEPTH];

    logic [1:0]                       ent_hit [RS_DEPTH];
    logic [1:0][DATA_WIDTH-1:0]       ent_fwd [RS_DEPTH];
    logic [1:0]                       disp_hit;
    logic [1:0][DATA_WIDTH-1:0]       disp_fwd;
    logic [RS_DEPTH-1:0]              elig;
    logic                             sel_vld;
    logic [IDX_W-1:0]                 sel_idx;
    logic [IDX_W-1:0]                 alloc_idx;
    logic [DATA_WIDTH-1:0]            sel_a;
    logic [DATA_WIDTH-1:0]            sel_b;
    logic                             do_alloc;
    logic                             do_issue;

    // Lowest-numbered matching CDB port wins; result is {hit, data}.
    function automatic logic [DATA_WIDTH:0] cdb_match(input logic [TAG_WIDTH-1:0] tag);
        logic [DATA_WIDTH:0] r;
        r = '0;
        for (int p = CDB_DEPTH - 1; p >= 0; p--)
            if (i_cdb_en[p] && i_cdb_tag[p] == tag) r = {1'b1, i_cdb_data[p]};
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++)
            for (int s = 0; s < 2; s++)
                {ent_hit[i][s], ent_fwd[i][s]} = cdb_match(src_tag_q[i][s]);
        for (int s = 0; s < 2; s++)
            {disp_hit[s], disp_fwd[s]} = cdb_match(i_rs_src_tag[s]);
    end

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
`ifdef RS_WAKEUP_BYPASS_EN
            elig[i] = valid_q[i] && (src_rdy_q[i][0] || ent_hit[i][0])
                                 && (src_rdy_q[i][1] || ent_hit[i][1]);
`else
            elig[i] = valid_q[i] && (&src_rdy_q[i]);
`endif
        end
    end

    // The oldest eligible entry is the one no other eligible entry is older than.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (elig[i] && ((elig & ~age_q[i] & ~(RS_DEPTH'(1) << i)) == '0)) begin
                sel_vld = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
        alloc_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--)
            if (!valid_q[i]) alloc_idx = IDX_W'(i);
    end

    always_comb begin
        sel_a = src_data_q[sel_idx][0];
        sel_b = src_data_q[sel_idx][1];
`ifdef RS_WAKEUP_BYPASS_EN
        if (!src_rdy_q[sel_idx][0]) sel_a = ent_fwd[sel_idx][0];
        if (!src_rdy_q[sel_idx][1]) sel_b = ent_fwd[sel_idx][1];
`endif
    end

    assign o_rs_stall = &valid_q;
    assign do_alloc   = i_rs_en && !o_rs_stall && !i_flush;
    assign do_issue   = sel_vld && !i_fu_stall && !i_flush;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            valid_q     <= '0;
            for (int i = 0; i < RS_DEPTH; i++) age_q[i] <= '0;
            o_fu_valid  <= 1'b0;
            o_fu_opcode <= '0;
            o_fu_iaddr  <= '0;
            o_fu_insn   <= '0;
            o_fu_src_a  <= '0;
            o_fu_src_b  <= '0;
            o_fu_tag    <= '0;
        end else if (i_flush) begin
            valid_q    <= '0;
            o_fu_valid <= 1'b0;
        end else begin
            if (do_issue) valid_q[sel_idx] <= 1'b0;
            if (do_alloc) begin
                valid_q[alloc_idx] <= 1'b1;
                age_q[alloc_idx]   <= '0;
                for (int j = 0; j < RS_DEPTH; j++)
                    if (valid_q[j]) age_q[j][alloc_idx] <= 1'b1;
            end
            if (!i_fu_stall) begin
                o_fu_valid <= sel_vld;
                if (sel_vld) begin
                    o_fu_opcode <= opcode_q[sel_idx];
                    o_fu_iaddr  <= iaddr_q[sel_idx];
                    o_fu_insn   <= insn_q[sel_idx];
                    o_fu_src_a  <= sel_a;
                    o_fu_src_b  <= sel_b;
                    o_fu_tag    <= dst_q[sel_idx];
                end
            end
        end
    end

    // Entry payload needs no reset: valid_q gates every use of it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < RS_DEPTH; i++)
            for (int s = 0; s < 2; s++)
                if (valid_q[i] && !src_rdy_q[i][s] && ent_hit[i][s]) begin
                    src_data_q[i][s] <= ent_fwd[i][s];
                    src_rdy_q[i][s]  <= 1'b1;
                end
        if (do_alloc) begin
            opcode_q[alloc_idx]  <= i_rs_opcode;
            iaddr_q[alloc_idx]   <= i_rs_iaddr;
            insn_q[alloc_idx]    <= i_rs_insn;
            dst_q[alloc_idx]     <= i_rs_dst_tag;
            src_tag_q[alloc_idx] <= i_rs_src_tag;
            for (int s = 0; s < 2; s++) begin
                if (!i_rs_src_rdy[s] && disp_hit[s]) begin
                    src_data_q[alloc_idx][s] <= disp_fwd[s];
                    src_rdy_q[alloc_idx][s]  <= 1'b1;
                end else begin
                    src_data_q[alloc_idx][s] <= i_rs_src_data[s];
                    src_rdy_q[alloc_idx][s]  <= i_rs_src_rdy[s];
                end
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed stimulus, age-ordered queue model checked every cycle, plus literal checks.
module tb_reservation_station;
    localparam int DEPTH = 8;
    localparam int CDB   = 2;

    logic                  clk = 1'b0;
    logic                  n_rst = 1'b0;
    logic                  flush = 1'b0;
    logic [CDB-1:0]        cdb_en = '0;
    logic [CDB-1:0][5:0]   cdb_tag = '0;
    logic [CDB-1:0][31:0]  cdb_data = '0;
    logic                  rs_en = 1'b0;
    logic [6:0]            rs_opcode = '0;
    logic [31:0]           rs_iaddr = '0;
    logic [31:0]           rs_insn = '0;
    logic [1:0][5:0]       rs_src_tag = '0;
    logic [1:0][31:0]      rs_src_data = '0;
    logic [1:0]            rs_src_rdy = '0;
    logic [5:0]            rs_dst_tag = '0;
    logic                  fu_stall = 1'b0;
    logic                  o_rs_stall, o_fu_valid;
    logic [6:0]            o_fu_opcode;
    logic [31:0]           o_fu_iaddr, o_fu_insn, o_fu_src_a, o_fu_src_b;
    logic [5:0]            o_fu_tag;

    int n_tests = 0;
    int n_fail  = 0;

    reservation_station #(.RS_DEPTH(DEPTH), .CDB_DEPTH(CDB), .DATA_WIDTH(32),
                          .ADDR_WIDTH(32), .TAG_WIDTH(6)) dut (
        .clk(clk), .n_rst(n_rst), .i_flush(flush),
        .i_cdb_en(cdb_en), .i_cdb_tag(cdb_tag), .i_cdb_data(cdb_data),
        .i_rs_en(rs_en), .i_rs_opcode(rs_opcode), .i_rs_iaddr(rs_iaddr), .i_rs_insn(rs_insn),
        .i_rs_src_tag(rs_src_tag), .i_rs_src_data(rs_src_data), .i_rs_src_rdy(rs_src_rdy),
        .i_rs_dst_tag(rs_dst_tag), .o_rs_stall(o_rs_stall), .i_fu_stall(fu_stall),
        .o_fu_valid(o_fu_valid), .o_fu_opcode(o_fu_opcode), .o_fu_iaddr(o_fu_iaddr),
        .o_fu_insn(o_fu_insn), .o_fu_src_a(o_fu_src_a), .o_fu_src_b(o_fu_src_b),
        .o_fu_tag(o_fu_tag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]       op;
        logic [31:0]      iaddr;
        logic [31:0]      insn;
        logic [5:0]       dst;
        logic [1:0][5:0]  stag;
        logic [1:0][31:0] sdat;
        logic [1:0]       srdy;
    } ent_t;

    ent_t        mq[$];
    logic        m_v = 1'b0;
    ent_t        m_out = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit cdb_find(input logic [5:0] tag, output logic [31:0] d);
        d = '0;
        for (int p = 0; p < CDB; p++)
            if (cdb_en[p] && cdb_tag[p] == tag) begin
                d = cdb_data[p];
                return 1'b1;
            end
        return 1'b0;
    endfunction

    function automatic bit src_ok(input ent_t e, input int s);
        logic [31:0] d;
        bit h;
        h = cdb_find(e.stag[s], d);
`ifdef RS_WAKEUP_BYPASS_EN
        return e.srdy[s] || h;
`else
        return e.srdy[s] == 1'b1 && (h || !h);
`endif
    endfunction

    // Model: entries kept in dispatch order, so the first ready one is the oldest.
    always @(posedge clk) begin : model
        ent_t        e;
        ent_t        n;
        int          sel;
        bit          full;
        logic [31:0] d;
        if (!n_rst) begin
            mq.delete();
            m_v   = 1'b0;
            m_out = '0;
        end else if (flush) begin
            mq.delete();
            m_v = 1'b0;
        end else begin
            full = (mq.size() == DEPTH);
            sel  = -1;
            e    = '0;
            for (int k = 0; k < mq.size(); k++)
                if (sel < 0 && src_ok(mq[k], 0) && src_ok(mq[k], 1)) sel = k;
            if (sel >= 0) begin
                e = mq[sel];
                for (int s = 0; s < 2; s++)
                    if (!e.srdy[s] && cdb_find(e.stag[s], d)) e.sdat[s] = d;
            end
            for (int k = 0; k < mq.size(); k++)
                for (int s = 0; s < 2; s++)
                    if (!mq[k].srdy[s] && cdb_find(mq[k].stag[s], d)) begin
                        mq[k].sdat[s] = d;
                        mq[k].srdy[s] = 1'b1;
                    end
            if (!fu_stall) begin
                if (sel >= 0) begin
                    m_v   = 1'b1;
                    m_out = e;
                    mq.delete(sel);
                end else begin
                    m_v = 1'b0;
                end
            end
            if (rs_en && !full) begin
                n.op = rs_opcode; n.iaddr = rs_iaddr; n.insn = rs_insn; n.dst = rs_dst_tag;
                n.stag = rs_src_tag;
                for (int s = 0; s < 2; s++) begin
                    if (!rs_src_rdy[s] && cdb_find(rs_src_tag[s], d)) begin
                        n.sdat[s] = d;
                        n.srdy[s] = 1'b1;
                    end else begin
                        n.sdat[s] = rs_src_data[s];
                        n.srdy[s] = rs_src_rdy[s];
                    end
                end
                mq.push_back(n);
            end
        end
    end

    always @(negedge clk) begin
        check("stall", 32'(o_rs_stall), 32'(mq.size() == DEPTH));
        check("fu_valid", 32'(o_fu_valid), 32'(m_v));
        if (m_v) begin
            check("fu_tag", 32'(o_fu_tag), 32'(m_out.dst));
            check("fu_src_a", o_fu_src_a, m_out.sdat[0]);
            check("fu_src_b", o_fu_src_b, m_out.sdat[1]);
            check("fu_opcode", 32'(o_fu_opcode), 32'(m_out.op));
            check("fu_iaddr", o_fu_iaddr, m_out.iaddr);
            check("fu_insn", o_fu_insn, m_out.insn);
        end
    end

    task automatic tick();
        @(negedge clk);
        rs_en  = 1'b0;
        cdb_en = '0;
        flush  = 1'b0;
    endtask

    task automatic disp(input logic [5:0] dst, input logic [5:0] t0, input logic r0,
                        input logic [31:0] d0, input logic [5:0] t1, input logic r1,
                        input logic [31:0] d1);
        rs_en       = 1'b1;
        rs_dst_tag  = dst;
        rs_opcode   = 7'(dst) + 7'd1;
        rs_iaddr    = 32'h1000 + 32'(dst) * 4;
        rs_insn     = 32'hDEAD0000 | 32'(dst);
        rs_src_tag  = {t1, t0};
        rs_src_rdy  = {r1, r0};
        rs_src_data = {d1, d0};
    endtask

    task automatic cdb(input int p, input logic [5:0] tag, input logic [31:0] data);
        cdb_en[p]   = 1'b1;
        cdb_tag[p]  = tag;
        cdb_data[p] = data;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(o_fu_valid), 32'd0);
        check("rst_stall", 32'(o_rs_stall), 32'd0);
        check("rst_tag", 32'(o_fu_tag), 32'd0);
        check("rst_src_a", o_fu_src_a, 32'd0);
        check("rst_opcode", 32'(o_fu_opcode), 32'd0);
        n_rst = 1'b1;
        tick();

        // Both sources ready: issue two cycles after dispatch.
        disp(6'd3, 6'd0, 1'b1, 32'd5, 6'd0, 1'b1, 32'd7);
        tick();
        check("t1_not_early", 32'(o_fu_valid), 32'd0);
        tick();
        check("t1_valid", 32'(o_fu_valid), 32'd1);
        check("t1_src_a", o_fu_src_a, 32'd5);
        check("t1_src_b", o_fu_src_b, 32'd7);
        check("t1_tag", 32'(o_fu_tag), 32'd3);
        check("t1_stall", 32'(o_rs_stall), 32'd0);
        tick();

        // Older entry waiting on tag 9; younger ready entry issues first.
        disp(6'd1, 6'd9, 1'b0, 32'd0, 6'd0, 1'b1, 32'h10);
        tick();
        disp(6'd2, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd2);
        tick();
        tick();
        check("t2_first_tag", 32'(o_fu_tag), 32'd2);
        cdb(0, 6'd9, 32'h42);
        tick();
`ifdef RS_WAKEUP_BYPASS_EN
        check("t2_byp_tag", 32'(o_fu_tag), 32'd1);
        check("t2_byp_src_a", o_fu_src_a, 32'h42);
`else
        check("t2_gap", 32'(o_fu_valid), 32'd0);
        tick();
        check("t2_second_tag", 32'(o_fu_tag), 32'd1);
        check("t2_src_a", o_fu_src_a, 32'h42);
        check("t2_src_b", o_fu_src_b, 32'h10);
`endif

        // Dispatch-cycle capture; two ports match, lower port's data wins.
        disp(6'd5, 6'd4, 1'b0, 32'd0, 6'd0, 1'b1, 32'h22);
        cdb(0, 6'd4, 32'h11);
        cdb(1, 6'd4, 32'h99);
        tick();
        tick();
        check("t3_tag", 32'(o_fu_tag), 32'd5);
        check("t3_src_a", o_fu_src_a, 32'h11);
        tick();

        // Fill under FU stall; extra dispatches are dropped.
        fu_stall = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            disp(6'(10 + k), 6'd0, 1'b1, 32'(k), 6'd0, 1'b1, 32'(k * 3));
            tick();
        end
        check("t4_full", 32'(o_rs_stall), 32'd1);
        check("t4_held_invalid", 32'(o_fu_valid), 32'd0);
        disp(6'd30, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0);
        tick();
        check("t4_still_full", 32'(o_rs_stall), 32'd1);
        fu_stall = 1'b0;
        disp(6'd32, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0);
        tick();
        check("t4_oldest", 32'(o_fu_tag), 32'd10);
        check("t4_unstall", 32'(o_rs_stall), 32'd0);
        disp(6'd31, 6'd0, 1'b1, 32'h31, 6'd0, 1'b1, 32'h13);
        tick();
        check("t4_second", 32'(o_fu_tag), 32'd11);
        repeat (7) tick();
        check("t4_last_tag", 32'(o_fu_tag), 32'd31);
        check("t4_last_src_a", o_fu_src_a, 32'h31);
        tick();
        check("t4_drained", 32'(o_fu_valid), 32'd0);

        // FU stall holds outputs; flush clears everything.
        disp(6'd40, 6'd0, 1'b1, 32'hA, 6'd0, 1'b1, 32'hB);
        tick();
        disp(6'd41, 6'd0, 1'b1, 32'hC, 6'd0, 1'b1, 32'hD);
        tick();
        fu_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t5_hold_tag", 32'(o_fu_tag), 32'd40);
            check("t5_hold_a", o_fu_src_a, 32'hA);
        end
        flush = 1'b1;
        tick();
        check("t5_flush_valid", 32'(o_fu_valid), 32'd0);
        fu_stall = 1'b0;
        tick();
        check("t5_flushed_entry", 32'(o_fu_valid), 32'd0);
        disp(6'd42, 6'd0, 1'b1, 32'h1, 6'd0, 1'b1, 32'h2);
        tick();
        tick();
        check("t5_after_flush", 32'(o_fu_tag), 32'd42);

        // Wakeup latency from a CDB broadcast of tag 6.
        disp(6'd50, 6'd6, 1'b0, 32'd0, 6'd0, 1'b1, 32'h3);
        tick();
        tick();
        cdb(1, 6'd6, 32'h66);
        tick();
`ifdef RS_WAKEUP_BYPASS_EN
        check("t6_byp_valid", 32'(o_fu_valid), 32'd1);
        check("t6_byp_a", o_fu_src_a, 32'h66);
`else
        check("t6_not_yet", 32'(o_fu_valid), 32'd0);
        tick();
        check("t6_valid", 32'(o_fu_valid), 32'd1);
        check("t6_src_a", o_fu_src_a, 32'h66);
`endif
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reservation_station.md
# reservation_station

Holds dispatched instructions until both source operands are available, then issues the oldest ready entry to its functional unit. Sits directly downstream of dispatch: receives the renamed opcode, instruction, source tags/data/ready bits and destination ROB tag. Snoops the common data bus (CDB) to capture results for pending operands, and drives a registered issue interface into the functional unit.

## Interface
Parameters:
- RS_DEPTH, 8: number of entries (power of two, ≥2)
- CDB_DEPTH, 2: number of CDB broadcast ports
- DATA_WIDTH, 32: operand/instruction width
- ADDR_WIDTH, 32: instruction address width
- TAG_WIDTH, 6: ROB tag width

Ports:
- clk  in  1  clock, all state on rising edge
- n_rst  in  1  asynchronous, active-low reset
- i_flush  in  1  discard all entries and any pending issue
- i_cdb_en[CDB_DEPTH]  in  1  CDB port valid
- i_cdb_tag[CDB_DEPTH]  in  TAG_WIDTH  tag of broadcast result
- i_cdb_data[CDB_DEPTH]  in  DATA_WIDTH  broadcast result
- i_rs_en  in  1  dispatch request
- i_rs_opcode  in  7  opcode
- i_rs_iaddr  in  ADDR_WIDTH  instruction address
- i_rs_insn  in  DATA_WIDTH  raw instruction
- i_rs_src_tag[2]  in  TAG_WIDTH  producer tag per source
- i_rs_src_data[2]  in  DATA_WIDTH  value per source (valid if rdy)
- i_rs_src_rdy[2]  in  1  source already available
- i_rs_dst_tag  in  TAG_WIDTH  destination ROB tag
- o_rs_stall  out  1  all entries occupied
- i_fu_stall  in  1  functional unit cannot accept
- o_fu_valid  out  1  issue valid
- o_fu_opcode  out  7; o_fu_iaddr  out  ADDR_WIDTH; o_fu_insn  out  DATA_WIDTH
- o_fu_src_a, o_fu_src_b  out  DATA_WIDTH  operand values
- o_fu_tag  out  TAG_WIDTH  destination ROB tag

## Operation
- Entry state: valid, opcode, iaddr, insn, dst tag, per source {tag, data, rdy}; RS_DEPTH×RS_DEPTH age matrix (bit[i][j]=1: entry i older than j).
- Allocate: i_rs_en && !o_rs_stall writes lowest-index free entry; age row set to "older than none", all other valid entries marked older than it. i_rs_en while o_rs_stall is ignored (no write, no error).
- Dispatch capture (mandatory): incoming source with rdy=0 whose tag matches an active CDB port in the same cycle is written with CDB data, rdy=1.
- Wakeup: every valid entry, each non-ready source compares against all CDB ports; match captures data and sets rdy. Multiple port matches on one tag: lowest port wins.
- Select: eligible = valid && both rdy (registered bits). Pick the eligible entry older than every other eligible entry.
- Issue: when !i_fu_stall, o_fu_* registers load the selected entry (o_fu_valid=1) and that entry's valid clears; with none eligible, o_fu_valid←0. When i_fu_stall, o_fu_* hold and no entry frees.
- o_rs_stall = occupied count == RS_DEPTH, from registered state only; freeing by issue unstalls the next cycle.
- Flush: highest priority; next edge all valid←0, o_fu_valid←0; same-cycle dispatch and issue discarded.
- Reset: all valid 0, age matrix 0, o_fu_valid 0, all o_fu_* 0, o_rs_stall 0.

## Timing
- Dispatch in cycle N with both sources ready → selectable N+1 → o_fu_valid in N+2.
- CDB wakeup of last missing source in cycle M → selectable M+1 → o_fu_valid M+2.
- Simultaneous allocate and issue of a different entry in one cycle: both occur.
- Full RS with issue in cycle N: dispatch in N still rejected; accepted in N+1.
- o_fu_* change only on rising edge; no combinational path from i_rs_* to o_fu_*.

## Configuration
- RS_WAKEUP_BYPASS_EN defined: an entry whose last missing source matches a CDB port in cycle M is eligible in M; CDB data is forwarded into o_fu_src_a/b; wakeup→o_fu_valid = 1 cycle (M+1). Age order still applies across registered and bypassed eligibles.
- Undefined: eligibility uses registered rdy bits only; wakeup→o_fu_valid = 2 cycles.

## Test plan
- Reset, dispatch OP with both rdy, src=5/7, tag 3 → o_fu_valid in N+2, src_a=5, src_b=7, o_fu_tag=3; o_rs_stall=0.
- Dispatch tag 1 waiting on tag 9, then tag 2 ready; CDB tag 9 data 0x42 → tag 2 issues first, tag 1 issues later with src_a=0x42.
- Dispatch src rdy=0 tag 4 with CDB tag 4 data 0x11 same cycle → entry captures 0x11; issues without further broadcast.
- Fill 8 entries, i_fu_stall=1 → o_rs_stall=1, 9th i_rs_en ignored; release stall → oldest issues first, o_rs_stall drops cycle after first issue.
- Hold i_fu_stall 3 cycles with o_fu_valid=1 → outputs stable; then i_flush → o_fu_valid=0, all entries invalid, next dispatch accepted.
- RS_WAKEUP_BYPASS_EN defined: CDB tag 6 wakes pending entry in M → o_fu_valid in M+1 with forwarded data.
